// File: rtl/uart_rx_axis.sv
// 8N1 UART receiver: 2-flop synchroniser, mid-bit sampling FSM, and a small
// FIFO presenting received bytes on an AXI-Stream-style byte interface.
module uart_rx_axis #(
  parameter int unsigned CLKS_PER_BIT = 278,
  parameter logic [7:0]  EOL_CHAR     = 8'h0A,
  parameter int unsigned DEPTH        = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_uart_rx,
  output logic [7:0] o_tdata,
  output logic       o_tlast,
  output logic       o_tvalid,
  input  logic       i_tready,
  output logic       o_frame_err,
  output logic       o_overrun
);

  localparam int unsigned CW   = $clog2(CLKS_PER_BIT);
  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned NW   = AW + 1;
  localparam int unsigned HALF = CLKS_PER_BIT / 2;

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_STOP, S_BREAK
  } state_t;

  logic          r_rx_meta, r_rx_s;
  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [2:0]    r_bit, w_bit_nxt;
  logic [7:0]    r_shift, w_shift_nxt;
  logic          w_push, w_ferr;

  logic [8:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr, w_rd_ptr_nxt;
  logic [NW-1:0] r_count, w_count_nxt;
  logic [7:0]    r_tdata;
  logic          r_tlast, r_tvalid, r_frame_err, r_overrun;
  logic          w_pop, w_wr, w_ovr;
  logic [8:0]    w_entry, w_head_nxt;

  // Receive state register and line synchroniser
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_bit     <= '0;
      r_shift   <= '0;
    end else begin
      r_rx_meta <= i_uart_rx;
      r_rx_s    <= r_rx_meta;
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_bit     <= w_bit_nxt;
      r_shift   <= w_shift_nxt;
    end
  end

  // Next-state: the baud counter counts down and a sample is taken when it hits zero
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_push      = 1'b0;
    w_ferr      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (!r_rx_s) begin
          w_state_nxt = S_START;
          w_cnt_nxt   = CW'(HALF - 1);
        end
      end
      S_START: begin
        if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - CW'(1);
        end else if (r_rx_s) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_DATA;
          w_cnt_nxt   = CW'(CLKS_PER_BIT - 1);
          w_bit_nxt   = 3'd0;
        end
      end
      S_DATA: begin
        if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - CW'(1);
        end else begin
          w_shift_nxt = {r_rx_s, r_shift[7:1]};
          w_cnt_nxt   = CW'(CLKS_PER_BIT - 1);
          if (r_bit == 3'd7) begin
            w_state_nxt = S_STOP;
          end else begin
            w_bit_nxt = r_bit + 3'd1;
          end
        end
      end
      S_STOP: begin
        if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - CW'(1);
        end else if (r_rx_s) begin
          w_push      = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_ferr      = 1'b1;
          w_state_nxt = S_BREAK;
        end
      end
      S_BREAK: begin
        if (r_rx_s) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FIFO control; a push into a full FIFO is allowed only alongside a pop
  always_comb begin
    w_pop        = r_tvalid & i_tready;
    w_wr         = w_push & ((r_count < NW'(DEPTH)) | w_pop);
    w_ovr        = w_push & ~w_wr;
    w_count_nxt  = r_count + NW'(w_wr) - NW'(w_pop);
    w_rd_ptr_nxt = r_rd_ptr + AW'(w_pop);
    w_entry      = {r_shift == EOL_CHAR, r_shift};
    w_head_nxt   = {r_tlast, r_tdata};
    if (w_wr && ((r_count - NW'(w_pop)) == '0)) begin
      w_head_nxt = w_entry;
    end else if (w_count_nxt != '0) begin
      w_head_nxt = r_mem[w_rd_ptr_nxt];
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= w_entry;
  end

  // Head beat is registered so tdata/tlast stay stable while stalled
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_tdata     <= '0;
      r_tlast     <= 1'b0;
      r_tvalid    <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_wr_ptr    <= r_wr_ptr + AW'(w_wr);
      r_rd_ptr    <= w_rd_ptr_nxt;
      r_count     <= w_count_nxt;
      r_tdata     <= w_head_nxt[7:0];
      r_tlast     <= w_head_nxt[8];
      r_tvalid    <= (w_count_nxt != '0);
      r_frame_err <= w_ferr;
      r_overrun   <= w_ovr;
    end
  end

  assign o_tdata     = r_tdata;
  assign o_tlast     = r_tlast;
  assign o_tvalid    = r_tvalid;
  assign o_frame_err = r_frame_err;
  assign o_overrun   = r_overrun;

endmodule

// File: tb/tb_uart_rx_axis.sv
// Scoreboard bench for uart_rx_axis: serial frames are driven bit by bit and
// a negedge monitor checks every delivered beat against the expected queue.
module tb_uart_rx_axis;

  localparam int unsigned CPB = 16;

  logic       clk;
  logic       i_rst;
  logic       rx;
  logic       tready;
  logic [7:0] tdata;
  logic       tlast;
  logic       tvalid;
  logic       frame_err;
  logic       overrun;

  logic [8:0]  exp_q [$];
  int unsigned n_vec;
  int unsigned n_err;
  int unsigned n_ferr;
  int unsigned n_ovr;
  logic        hold_prev;
  logic [8:0]  hold_val;

  uart_rx_axis #(.CLKS_PER_BIT(CPB), .EOL_CHAR(8'h0A), .DEPTH(4)) dut (
    .i_clk       (clk),
    .i_rst       (i_rst),
    .i_uart_rx   (rx),
    .o_tdata     (tdata),
    .o_tlast     (tlast),
    .o_tvalid    (tvalid),
    .i_tready    (tready),
    .o_frame_err (frame_err),
    .o_overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One 8N1 frame, one bit per CPB cycles; the expected beat is queued up front
  task automatic send_byte(input logic [7:0] b, input logic stop_bit, input logic expect_beat);
    if (expect_beat) exp_q.push_back({b == 8'h0A, b});
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(CPB);
    end
    rx = stop_bit;
    tick(CPB);
    rx = 1'b1;
  endtask

  task automatic wait_drain(input int max_cycles);
    for (int i = 0; i < max_cycles; i++) begin
      if (exp_q.size() == 0 && !tvalid) break;
      tick(1);
    end
    check("drain_queue", 32'(exp_q.size()), 32'd0);
    check("drain_tvalid", 32'(tvalid), 32'd0);
  endtask

  // Monitor: pops the scoreboard on every handshake, checks stall stability, counts pulses
  always @(negedge clk) begin
    if (i_rst) begin
      hold_prev = 1'b0;
    end else begin
      if (frame_err) n_ferr++;
      if (overrun)   n_ovr++;
      if (hold_prev) check("stall_stable", {23'd0, tvalid, tlast, tdata}, {23'd1, hold_val});
      if (tvalid && tready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_beat: got %0h expected none at %0t", {tlast, tdata}, $time);
        end else begin
          check("beat", {23'd0, tlast, tdata}, {23'd0, exp_q.pop_front()});
        end
      end
      hold_prev = tvalid && !tready;
      hold_val  = {tlast, tdata};
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_vec = 0; n_err = 0; n_ferr = 0; n_ovr = 0;
    hold_prev = 1'b0; hold_val = '0;
    i_rst = 1'b1; rx = 1'b1; tready = 1'b1;
    tick(3);
    i_rst = 1'b0;
    check("rst_tvalid", 32'(tvalid), 32'd0);
    check("rst_tdata", 32'(tdata), 32'd0);
    check("rst_tlast", 32'(tlast), 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    tick(4);

    // Single byte with latency check: stop mid-sample lands 155 cycles after start edge
    fork
      send_byte(8'h55, 1'b1, 1'b1);
      begin
        tick(154);
        @(negedge clk);
        check("latency_pre", 32'(tvalid), 32'd0);
        @(negedge clk);
        check("latency_rise", 32'(tvalid), 32'd1);
      end
    join
    wait_drain(100);

    // Back-to-back frames, tlast only on the EOL byte
    send_byte(8'h41, 1'b1, 1'b1);
    send_byte(8'h42, 1'b1, 1'b1);
    send_byte(8'h0A, 1'b1, 1'b1);
    wait_drain(100);

    // Short glitch is ignored, then a real frame
    rx = 1'b0;
    tick(5);
    rx = 1'b1;
    tick(3 * CPB);
    check("glitch_no_ferr", n_ferr, 32'd0);
    send_byte(8'hA3, 1'b1, 1'b1);
    wait_drain(100);

    // Framing error followed by a long break
    send_byte(8'h3C, 1'b0, 1'b0);
    rx = 1'b0;
    tick(40 * CPB);
    rx = 1'b1;
    tick(2 * CPB);
    check("ferr_once", n_ferr, 32'd1);
    send_byte(8'h01, 1'b1, 1'b1);
    wait_drain(100);
    check("ferr_still_once", n_ferr, 32'd1);

    // Fill a stalled FIFO; the fifth byte overruns
    tready = 1'b0;
    for (int i = 0; i < 5; i++) send_byte(8'(8'h10 + i), 1'b1, i < 4);
    tick(CPB);
    check("full_tvalid", 32'(tvalid), 32'd1);
    check("full_head", 32'(tdata), 32'h10);
    check("overrun_once", n_ovr, 32'd1);
    tready = 1'b1;
    wait_drain(100);

    // Reset mid-frame with two bytes queued
    tready = 1'b0;
    send_byte(8'h20, 1'b1, 1'b1);
    send_byte(8'h21, 1'b1, 1'b1);
    check("prereset_tvalid", 32'(tvalid), 32'd1);
    rx = 1'b0;
    tick(CPB);
    rx = 1'b1;
    tick(3 * CPB);
    i_rst = 1'b1;
    exp_q.delete();
    tick(1);
    i_rst = 1'b0;
    check("midrst_tvalid", 32'(tvalid), 32'd0);
    check("midrst_tdata", 32'(tdata), 32'd0);
    check("midrst_frame_err", 32'(frame_err), 32'd0);
    check("midrst_overrun", 32'(overrun), 32'd0);
    tick(2 * CPB);
    tready = 1'b1;
    send_byte(8'h7E, 1'b1, 1'b1);
    wait_drain(100);

    check("final_ferr", n_ferr, 32'd1);
    check("final_overrun", n_ovr, 32'd1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_rx_axis.md
Name: uart_rx_axis

Overview:
UART receiver, the inbound counterpart to the transmit-side emitter. Samples an asynchronous 8N1 serial line, recovers bytes LSB-first and delivers them on an AXI-Stream-style byte interface (tdata/tlast/tvalid/tready) through a small FIFO. Sits between the board RX pin and a byte consumer, for example a command parser feeding the core array.

Parameters:
CLKS_PER_BIT, 278, i_clk cycles per bit period (≥ 4); 278 ≈ 16 MHz / 57600 baud
EOL_CHAR, 8'h0A, received byte value that raises o_tlast for that beat
DEPTH, 4, FIFO entries; power of two, ≥ 2

Ports:
i_clk  input  1  system clock
i_rst  input  1  synchronous reset, active-high
i_uart_rx  input  1  asynchronous serial line, idle high
o_tdata  output  8  received byte at FIFO head
o_tlast  output  1  head byte equals EOL_CHAR
o_tvalid  output  1  FIFO non-empty
i_tready  input  1  consumer accepts head beat
o_frame_err  output  1  one-cycle pulse: stop bit sampled low, byte discarded
o_overrun  output  1  one-cycle pulse: valid byte dropped because FIFO full

Behaviour:
- Reset is synchronous and active-high. On reset: synchroniser flops = 1, FSM = IDLE, bit counter = 0, FIFO empty, o_tvalid = 0, o_tdata = 0, o_tlast = 0, o_frame_err = 0, o_overrun = 0.
- i_uart_rx passes through a 2-flop synchroniser (rx_s). All sampling uses rx_s.
- FSM states and transitions:
  - IDLE: when rx_s = 0, load baud counter and go to START.
  - START: wait CLKS_PER_BIT/2 cycles (integer division), then sample. rx_s = 1 → glitch, return to IDLE with nothing pushed and no error. rx_s = 0 → reload counter, go to DATA.
  - DATA: sample every CLKS_PER_BIT cycles. Shift each sample into bit[n] for n = 0..7, LSB first. After the 8th sample go to STOP.
  - STOP: sample after CLKS_PER_BIT cycles.
    - rx_s = 1 → push {byte == EOL_CHAR, byte} into the FIFO, go to IDLE.
    - rx_s = 0 → pulse o_frame_err, discard the byte, go to BREAK.
  - BREAK: wait until rx_s = 1, then go to IDLE. This prevents a held-low line from being read as repeated frames.
- Returning to IDLE at the stop-bit mid-point lets a back-to-back start bit be detected with no dead bit time.
- Baud counter width is $clog2(CLKS_PER_BIT). It reloads on every state entry. It does not run in IDLE or BREAK.
- FIFO (DEPTH × 9 bits):
  - Pop occurs when o_tvalid && i_tready.
  - Push succeeds when count < DEPTH, or when count == DEPTH and a pop happens in the same cycle (simultaneous push+pop at full keeps count at DEPTH).
  - Otherwise the byte is dropped and o_overrun pulses for one cycle; FIFO contents are unchanged.
- Stream rules:
  - o_tvalid = (count != 0).
  - o_tdata and o_tlast present the head entry and are registered/read from the head pointer.
  - While o_tvalid && !i_tready, o_tdata and o_tlast hold stable.
  - o_tvalid never drops without a handshake, except on reset.
- Latency: the pushed byte appears with o_tvalid = 1 on the cycle after the stop-bit sample when the FIFO was empty.
- Pointers wrap modulo DEPTH. Count is $clog2(DEPTH)+1 bits.
- Reset mid-frame: abandons reception, FIFO is emptied, no pulse is generated. The FSM resumes in IDLE; if the line is still low it treats that as a start bit.

Test Plan:
- CLKS_PER_BIT=16; send 0x55 with i_tready=1 → exactly one beat, o_tdata=0x55, o_tlast=0; o_tvalid rises 1 cycle after the stop-bit mid-sample.
- Send 0x41, 0x42, 0x0A back-to-back (no idle gap) with i_tready=1 → three beats 0x41/0x42/0x0A in order; o_tlast=1 only on 0x0A.
- Low pulse of 5 cycles on idle line → no beat, no o_frame_err; a following valid 0xA3 frame is received correctly.
- Frame 0x3C with the stop bit driven low, line then held low for 40 bit times and released → one o_frame_err pulse, no beat, no further errors; the next frame 0x01 is received.
- i_tready=0, send 5 bytes 0x10..0x14 with DEPTH=4 → first four held with o_tdata=0x10 stable and o_tvalid=1; one o_overrun pulse on the 5th; then raise i_tready → 0x10..0x13 drain, count reaches 0.
- Assert i_rst during DATA of a frame while 2 bytes are queued → next cycle o_tvalid=0 and both pulse outputs 0; a subsequent 0x7E frame is received as a single beat.
